timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped programmable down-counter device: the interrupt source feeding the coprocessor's 6-bit hardware-interrupt input.
- The system bridge decodes the CPU store/load address into the device's register index and write enable.
- The `irq` output connects to HWInt[0].
- Supports one-shot (mode 0) and auto-reload periodic (mode 1) operation, controlled by CTRL, PRESET and COUNT registers.

Parameters:
- WIDTH, 32: width of PRESET, COUNT, and the data buses.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- addr  in  2  word index: 0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped.
- we  in  1  write enable from bridge; sampled at rising edge.
- din  in  WIDTH  write data (GPR[rt] of the store).
- dout  out  WIDTH  combinational read data for `addr`.
- irq  out  1  interrupt request to CP0 HWInt[0].

Behaviour:
- Registers:
  - CTRL[0]=En, CTRL[2:1]=Mode, CTRL[3]=IM. Bits [31:4] are not stored and read 0.
  - PRESET: fully writable.
  - COUNT: read-only; writes are ignored.
  - addr 3: reads 0, writes ignored.
- Reset (async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Therefore dout reflects zeros and irq=0 while reset is high. Reset asserted mid-count aborts the count immediately.
- irq = irq_flag & CTRL.IM. This is combinational from registers: no glitching, no extra latency.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if En=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT:
    - if En=0 -> IDLE, COUNT holds.
    - else if COUNT>1: COUNT<=COUNT-1.
    - else (COUNT is 1 or 0): COUNT<=0, irq_flag<=1, -> INT.
  - INT:
    - Mode 1: irq_flag<=0; -> LOAD (auto-reload).
    - Mode 0, 2 or 3 (2 and 3 are reserved and behave as mode 0): CTRL.En<=0; -> IDLE. irq_flag stays 1.
- Timing:
  - CPU writes En=1 at edge t0: LOAD at t1, CNT with COUNT=PRESET at t2, INT (irq high) at edge t2+max(PRESET,1).
  - PRESET=0 therefore behaves as PRESET=1.
  - Mode 1 period is PRESET+2 cycles, with irq high for exactly 1 cycle per period.
- Mode-0 irq stays high until any CPU write to CTRL, which clears irq_flag at that edge.
- Simultaneous events:
  - A CPU CTRL write in the same cycle the FSM clears En (INT, mode 0): the CPU-written value wins, and irq_flag clears.
  - A CPU CTRL write in the same cycle irq_flag would be set (CNT->INT): set wins, and irq_flag=1.
  - A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
- Mid-count writes:
  - Writing En=0 during CNT stops the count within one edge; COUNT is frozen and readable.
  - Re-enabling restarts from LOAD, so COUNT is reloaded from PRESET.
  - Writing Mode during CNT takes effect at the next INT.
- Arithmetic: WIDTH-bit unsigned; the COUNT>1 check prevents underflow wrap.

Decomposition:
- Shared constants include, alongside the existing CP0 definitions:
  - register indices TC_CTRL=0, TC_PRESET=1, TC_COUNT=2;
  - CTRL field macros (En bit 0, Mode bits 2:1, IM bit 3);
  - the 2-bit state encodings IDLE/LOAD/CNT/INT;
  - mode codes MODE_ONESHOT=0, MODE_PERIODIC=1.
- No sub-module: a single module holds the register file, FSM and read mux.

Test Plan:
- Reset check: assert reset mid-count (COUNT=3, state CNT) without a clock edge -> COUNT, CTRL and irq read 0 immediately. After release, the FSM stays IDLE.
- One-shot: PRESET=5, then CTRL=0x9 (En, mode 0, IM) at edge t0 -> COUNT reads 5,4,3,2,1 at t2..t6, irq=1 from t7. CTRL reads 0x8, irq stays high for 20 cycles, and a write CTRL=0x8 drops irq next cycle.
- Periodic: PRESET=3, CTRL=0xB -> irq one-cycle pulses exactly every 5 cycles for 4 periods; CTRL.En stays 1.
- Masking and boundary: PRESET=0, CTRL=0x1 (IM=0) -> INT reached at t3 with irq=0. Then writing CTRL=0x8 clears the flag, so irq remains 0.
- Stop/resume and write collisions: during CNT (COUNT=7, PRESET=10), write CTRL=0x8 -> COUNT frozen at 6. Write PRESET=2, then CTRL=0x9 -> reload to 2 and irq after 2 more edges. A CTRL write coinciding with CNT->INT leaves irq=1.
- Bus decode: writes to COUNT (addr 2) and addr 3 are ignored. Reading addr 3 returns 0. A CTRL write of 0xFFFFFFFF reads back 0x0000000F.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the programmable timer/counter: register map, CTRL fields,
// FSM state encodings and mode codes, alongside the CP0 interrupt constants.
package timer_counter_pkg;

    localparam int CP0_HWINT_W  = 6;
    localparam int TC_HWINT_IDX = 0;

    localparam int TC_ADDR_W = 2;
    localparam logic [TC_ADDR_W-1:0] TC_CTRL   = 2'd0;
    localparam logic [TC_ADDR_W-1:0] TC_PRESET = 2'd1;
    localparam logic [TC_ADDR_W-1:0] TC_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_BITS    = 4;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    // Only the low CTRL bits are stored; the rest read back as zero.
    function automatic logic [CTRL_BITS-1:0] ctrl_pack(input logic en,
                                                       input logic [1:0] mode,
                                                       input logic im);
        return {im, mode, en};
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer: decoded word index, write strobe, data and the irq line.
interface timer_counter_if
    import timer_counter_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic [TC_ADDR_W-1:0] addr;
    logic                 we;
    logic [WIDTH-1:0]     din;
    logic [WIDTH-1:0]     dout;
    logic                 irq;

    modport master (output addr, output we, output din, input dout, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq);

endinterface

// File: rtl/timer_counter.sv
// Programmable down-counter timer: CTRL/PRESET/COUNT register file, counting FSM and
// combinational read mux. irq drives CP0 HWInt[0].
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    tc_state_e        state_r;
    tc_state_e        state_nxt_s;
    logic             en_r;
    logic             en_nxt_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_nxt_s;
    logic             im_r;
    logic             im_nxt_s;
    logic             irq_flag_r;
    logic             irq_flag_nxt_s;
    logic [WIDTH-1:0] preset_r;
    logic [WIDTH-1:0] preset_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ctrl_wr_s;
    logic             preset_wr_s;
    logic             flag_set_s;
    logic             flag_clr_s;
    logic             fsm_en_clr_s;
    logic [WIDTH-1:0] dout_s;

    // Next-state logic for the counting FSM and all register updates.
    always_comb begin
        ctrl_wr_s    = bus.we && (bus.addr == TC_CTRL);
        preset_wr_s  = bus.we && (bus.addr == TC_PRESET);
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        flag_set_s   = 1'b0;
        flag_clr_s   = 1'b0;
        fsm_en_clr_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (en_r) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                count_nxt_s = preset_r;
                state_nxt_s = CNT;
            end
            CNT: begin
                if (!en_r) begin
                    state_nxt_s = IDLE;
                end else if (count_r > COUNT_ONE) begin
                    count_nxt_s = count_r - COUNT_ONE;
                end else begin
                    // Terminal count of 1 or 0 never wraps below zero.
                    count_nxt_s = '0;
                    flag_set_s  = 1'b1;
                    state_nxt_s = INT;
                end
            end
            INT: begin
                if (mode_r == MODE_PERIODIC) begin
                    flag_clr_s  = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    fsm_en_clr_s = 1'b1;
                    state_nxt_s  = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // A CPU CTRL write overrides the FSM clearing En.
        if (ctrl_wr_s) begin
            en_nxt_s   = bus.din[CTRL_EN];
            mode_nxt_s = bus.din[CTRL_MODE_HI:CTRL_MODE_LO];
            im_nxt_s   = bus.din[CTRL_IM];
        end else if (fsm_en_clr_s) begin
            en_nxt_s   = 1'b0;
            mode_nxt_s = mode_r;
            im_nxt_s   = im_r;
        end else begin
            en_nxt_s   = en_r;
            mode_nxt_s = mode_r;
            im_nxt_s   = im_r;
        end

        // Setting the flag wins over any clear in the same cycle.
        if (flag_set_s) begin
            irq_flag_nxt_s = 1'b1;
        end else if (flag_clr_s || ctrl_wr_s) begin
            irq_flag_nxt_s = 1'b0;
        end else begin
            irq_flag_nxt_s = irq_flag_r;
        end

        if (preset_wr_s) begin
            preset_nxt_s = bus.din;
        end else begin
            preset_nxt_s = preset_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Register file and interrupt flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r       <= 1'b0;
            mode_r     <= 2'd0;
            im_r       <= 1'b0;
            irq_flag_r <= 1'b0;
            preset_r   <= '0;
            count_r    <= '0;
        end else begin
            en_r       <= en_nxt_s;
            mode_r     <= mode_nxt_s;
            im_r       <= im_nxt_s;
            irq_flag_r <= irq_flag_nxt_s;
            preset_r   <= preset_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

    // Read mux; unmapped index reads zero.
    always_comb begin
        dout_s = '0;
        case (bus.addr)
            TC_CTRL:   dout_s = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl_pack(en_r, mode_r, im_r)};
            TC_PRESET: dout_s = preset_r;
            TC_COUNT:  dout_s = count_r;
            default:   dout_s = '0;
        endcase
    end

    assign bus.dout = dout_s;
    assign bus.irq  = irq_flag_r & im_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized trials
// checked against a cycle-timing model derived from the register/timing rules.
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    timer_counter_if #(.WIDTH(32)) bus ();

    timer_counter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_edge(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #2;
        bus.we   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.dout;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 32'd0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Timing model: k = edges since the enabling CTRL write (k >= 2 for count).
    function automatic logic [31:0] model_count(input int k, input int p, input logic [1:0] md);
        int pe;
        int j;
        pe = (p < 1) ? 1 : p;
        if (md == MODE_PERIODIC) begin
            j = (k - 2) % (pe + 2);
            return (j < pe) ? 32'(p - j) : 32'd0;
        end
        return (k < 2 + pe) ? 32'(p - (k - 2)) : 32'd0;
    endfunction

    function automatic logic model_irq(input int k, input int p, input logic [1:0] md, input logic im);
        int pe;
        pe = (p < 1) ? 1 : p;
        if (k < 2) return 1'b0;
        if (md == MODE_PERIODIC) return im && (((k - 2) % (pe + 2)) == pe);
        return im && (k >= 2 + pe);
    endfunction

    function automatic logic [31:0] model_ctrl(input int k, input int p, input logic [1:0] md, input logic im);
        int   pe;
        logic en;
        pe = (p < 1) ? 1 : p;
        en = (md == MODE_PERIODIC) ? 1'b1 : (k <= 2 + pe);
        return {28'd0, im, md, en};
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        apply_reset();
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_ctrl got=%0h exp=0", v); end
        rd(TC_PRESET, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_preset got=%0h exp=0", v); end
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_count got=%0h exp=0", v); end
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end

        wr_edge(TC_PRESET, 32'd5);
        wr_edge(TC_CTRL, 32'h9);
        repeat (4) step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd3) begin miscompares++; $display("FAIL midcount_pre got=%0h exp=3", v); end
        reset = 1'b1;
        #1;
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL async_count got=%0h exp=0", v); end
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL async_ctrl got=%0h exp=0", v); end
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL async_irq got=%b exp=0", bus.irq); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        wr_edge(TC_PRESET, 32'd6);
        for (int i = 0; i < 3; i++) begin
            step();
            rd(TC_COUNT, v);
            vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL post_reset_idle c=%0d got=%0h exp=0", i, v); end
        end
    endtask

    task automatic test_bus_decode();
        logic [31:0] v;
        logic [31:0] pv;
        apply_reset();
        pv = $urandom;
        wr_edge(TC_PRESET, pv);
        wr_edge(TC_COUNT, $urandom);
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL count_ro got=%0h exp=0", v); end
        wr_edge(2'd3, $urandom);
        rd(2'd3, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL addr3_read got=%0h exp=0", v); end
        rd(TC_PRESET, v);
        vectors++; if (v !== pv) begin miscompares++; $display("FAIL preset_rb got=%0h exp=%0h", v, pv); end
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL ctrl_untouched got=%0h exp=0", v); end
        wr_edge(TC_CTRL, 32'hFFFF_FFFF);
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'h0000_000F) begin miscompares++; $display("FAIL ctrl_mask got=%0h exp=f", v); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        apply_reset();
        wr_edge(TC_PRESET, 32'd5);
        wr_edge(TC_CTRL, 32'h9);
        step();
        for (int k = 2; k <= 6; k++) begin
            step();
            rd(TC_COUNT, v);
            vectors++; if (v !== 32'(7 - k)) begin miscompares++; $display("FAIL oneshot_count t%0d got=%0h exp=%0h", k, v, 7 - k); end
            vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_early_irq t%0d got=%b exp=0", k, bus.irq); end
        end
        step();
        vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL oneshot_irq_t7 got=%b exp=1", bus.irq); end
        step();
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'h8) begin miscompares++; $display("FAIL oneshot_en_clr got=%0h exp=8", v); end
        for (int i = 0; i < 20; i++) begin
            vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL oneshot_irq_hold c=%0d got=%b exp=1", i, bus.irq); end
            step();
        end
        wr_edge(TC_CTRL, 32'h8);
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_irq_ack got=%b exp=0", bus.irq); end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        logic        exp_irq;
        apply_reset();
        wr_edge(TC_PRESET, 32'd3);
        wr_edge(TC_CTRL, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            step();
            exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
            vectors++; if (bus.irq !== exp_irq) begin miscompares++; $display("FAIL periodic_irq t%0d got=%b exp=%b", k, bus.irq, exp_irq); end
        end
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'hB) begin miscompares++; $display("FAIL periodic_en got=%0h exp=b", v); end
    endtask

    task automatic test_mask_boundary();
        logic [31:0] v;
        apply_reset();
        wr_edge(TC_PRESET, 32'd0);
        wr_edge(TC_CTRL, 32'h1);
        repeat (2) step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL p0_count got=%0h exp=0", v); end
        step();
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'h1) begin miscompares++; $display("FAIL p0_ctrl_t3 got=%0h exp=1", v); end
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL p0_masked_irq got=%b exp=0", bus.irq); end
        step();
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'h0) begin miscompares++; $display("FAIL p0_ctrl_t4 got=%0h exp=0", v); end
        wr_edge(TC_CTRL, 32'h8);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL p0_unmask_irq c=%0d got=%b exp=0", i, bus.irq); end
            step();
        end
    endtask

    task automatic test_stop_resume();
        logic [31:0] v;
        apply_reset();
        wr_edge(TC_PRESET, 32'd10);
        wr_edge(TC_CTRL, 32'h9);
        repeat (5) step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd7) begin miscompares++; $display("FAIL stop_pre got=%0h exp=7", v); end
        wr_edge(TC_CTRL, 32'h8);
        for (int i = 0; i < 4; i++) begin
            rd(TC_COUNT, v);
            vectors++; if (v !== 32'd6) begin miscompares++; $display("FAIL stop_frozen c=%0d got=%0h exp=6", i, v); end
            step();
        end
        wr_edge(TC_PRESET, 32'd2);
        wr_edge(TC_CTRL, 32'h9);
        step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd6) begin miscompares++; $display("FAIL resume_t1 got=%0h exp=6", v); end
        step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd2) begin miscompares++; $display("FAIL resume_reload got=%0h exp=2", v); end
        step();
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL resume_irq_t3 got=%b exp=0", bus.irq); end
        step();
        vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL resume_irq_t4 got=%b exp=1", bus.irq); end

        wr_edge(TC_PRESET, 32'd3);
        wr_edge(TC_CTRL, 32'h9);
        repeat (4) step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd1) begin miscompares++; $display("FAIL coll_pre got=%0h exp=1", v); end
        wr_edge(TC_CTRL, 32'h9);
        vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL coll_set_wins got=%b exp=1", bus.irq); end
        wr_edge(TC_CTRL, 32'h9);
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL coll_flag_clr got=%b exp=0", bus.irq); end
        rd(TC_CTRL, v);
        vectors++; if (v !== 32'h9) begin miscompares++; $display("FAIL coll_cpu_wins got=%0h exp=9", v); end
        repeat (2) step();
        rd(TC_COUNT, v);
        vectors++; if (v !== 32'd3) begin miscompares++; $display("FAIL coll_restart got=%0h exp=3", v); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] exp_v;
        logic        exp_irq;
        for (int t = 0; t < 10; t++) begin
            int         p;
            int         n;
            logic [1:0] md;
            logic       im;
            p  = int'($urandom_range(0, 9));
            md = 2'($urandom_range(0, 3));
            im = 1'($urandom_range(0, 1));
            n  = 2 * (((p < 1) ? 1 : p) + 2) + 4;
            apply_reset();
            wr_edge(TC_PRESET, 32'(p));
            wr_edge(TC_CTRL, {28'd0, im, md, 1'b1});
            for (int k = 1; k <= n; k++) begin
                step();
                exp_irq = model_irq(k, p, md, im);
                vectors++; if (bus.irq !== exp_irq) begin miscompares++; $display("FAIL rnd_irq p=%0d m=%0d im=%b k=%0d got=%b exp=%b", p, md, im, k, bus.irq, exp_irq); end
                exp_v = model_ctrl(k, p, md, im);
                rd(TC_CTRL, v);
                vectors++; if (v !== exp_v) begin miscompares++; $display("FAIL rnd_ctrl p=%0d m=%0d k=%0d got=%0h exp=%0h", p, md, k, v, exp_v); end
                if (k >= 2) begin
                    exp_v = model_count(k, p, md);
                    rd(TC_COUNT, v);
                    vectors++; if (v !== exp_v) begin miscompares++; $display("FAIL rnd_count p=%0d m=%0d k=%0d got=%0h exp=%0h", p, md, k, v, exp_v); end
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.we      = 1'b0;
        bus.addr    = 2'd0;
        bus.din     = 32'd0;
        test_reset();
        test_bus_decode();
        test_oneshot();
        test_periodic();
        test_mask_boundary();
        test_stop_resume();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
